// File: rtl/mini_src_step_ctrl.sv
// Mini-SRC T-state control sequencer: fetch/decode/execute of R- and I-type ALU
// instructions with memory-ready wait/timeout, single-step gating and halt/fault states.
module mini_src_step_ctrl #(
   parameter int MEM_TIMEOUT = 15,
   parameter int OP_MSB      = 31
) (
   input  logic        clock,
   input  logic        clear,
   input  logic [31:0] ir,
   input  logic        mem_rdy,
   input  logic        run,
   input  logic        step_en,
   input  logic        step_req,
   output logic        PCout,
   output logic        MARin,
   output logic        IncPC,
   output logic        PCin,
   output logic        Read,
   output logic        MDRin,
   output logic        MDRout,
   output logic        IRin,
   output logic        Gra,
   output logic        Grb,
   output logic        Grc,
   output logic        Rout,
   output logic        Rin,
   output logic        Yin,
   output logic        Cout,
   output logic        Zlowin,
   output logic        Zlowout,
   output logic [4:0]  alu_op,
   output logic [3:0]  state,
   output logic        busy,
   output logic        illegal,
   output logic        mem_timeout
);

   typedef enum logic [3:0] {
      S_IDLE = 4'b0000,
      S_T0   = 4'b0111,
      S_T1   = 4'b1000,
      S_T2   = 4'b1001,
      S_T3   = 4'b1010,
      S_T4   = 4'b1011,
      S_T5   = 4'b1100,
      S_ERR  = 4'b1110,
      S_HALT = 4'b1111
   } state_t;

   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_ADDI = 5'b01100;
   localparam logic [4:0] OP_ANDI = 5'b01101;
   localparam logic [4:0] OP_ORI  = 5'b01110;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;
   localparam logic [7:0] TMO     = 8'(MEM_TIMEOUT);

   state_t     cur, nxt;
   logic [7:0] wait_cnt;
   logic [4:0] opcode;
   logic [4:0] imm_op;
   logic       adv, is_r, is_i, ill_set, tmo_set;

   assign opcode = ir[OP_MSB -: 5];
   assign adv    = !step_en | step_req;
   assign is_r   = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                   (opcode == OP_AND) || (opcode == OP_OR);
   assign is_i   = (opcode == OP_ADDI) || (opcode == OP_ANDI) || (opcode == OP_ORI);

   always_comb begin
      case (opcode)
         OP_ANDI: imm_op = OP_AND;
         OP_ORI:  imm_op = OP_OR;
         default: imm_op = OP_ADD;
      endcase
   end

   always_comb begin
      nxt     = cur;
      ill_set = 1'b0;
      tmo_set = 1'b0;
      PCout   = 1'b0; MARin  = 1'b0; IncPC = 1'b0; PCin = 1'b0;
      Read    = 1'b0; MDRin  = 1'b0; MDRout = 1'b0; IRin = 1'b0;
      Gra     = 1'b0; Grb    = 1'b0; Grc   = 1'b0; Rout = 1'b0; Rin = 1'b0;
      Yin     = 1'b0; Cout   = 1'b0; Zlowin = 1'b0; Zlowout = 1'b0;
      alu_op  = 5'b0;
      case (cur)
         S_IDLE: if (run && adv) nxt = S_T0;
         S_T0: begin
            PCout = adv; MARin = adv; IncPC = adv; PCin = adv;
            if (adv) nxt = S_T1;
         end
         S_T1: begin
            Read  = 1'b1;
            MDRin = mem_rdy & adv;
            // Timeout is judged on mem_rdy alone so a stalled step still faults.
            if (mem_rdy && adv) nxt = S_T2;
            else if (!mem_rdy && wait_cnt >= TMO) begin
               nxt     = S_ERR;
               tmo_set = 1'b1;
            end
         end
         S_T2: begin
            MDRout = adv; IRin = adv;
            if (adv) nxt = S_T3;
         end
         S_T3: begin
            if (is_r || is_i) begin
               Grb = adv; Rout = adv; Yin = adv;
               if (adv) nxt = S_T4;
            end else if (opcode == OP_NOP) begin
               if (adv) nxt = run ? S_T0 : S_IDLE;
            end else if (opcode == OP_HALT) begin
               if (adv) nxt = S_HALT;
            end else if (adv) begin
               nxt     = S_ERR;
               ill_set = 1'b1;
            end
         end
         S_T4: begin
            if (is_r) begin
               Grc = adv; Rout = adv; Zlowin = adv;
               alu_op = adv ? opcode : 5'b0;
            end else if (is_i) begin
               Cout = adv; Zlowin = adv;
               alu_op = adv ? imm_op : 5'b0;
            end
            if (adv) nxt = S_T5;
         end
         S_T5: begin
            Zlowout = adv; Gra = adv; Rin = adv;
            if (adv) nxt = run ? S_T0 : S_IDLE;
         end
         default: nxt = cur;
      endcase
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         cur         <= S_IDLE;
         wait_cnt    <= 8'd0;
         illegal     <= 1'b0;
         mem_timeout <= 1'b0;
      end else begin
         cur <= nxt;
         // Held at zero outside T1, so every T1 entry starts a fresh count.
         if (cur != S_T1)  wait_cnt <= 8'd0;
         else if (!mem_rdy) wait_cnt <= wait_cnt + 8'd1;
         if (ill_set) illegal     <= 1'b1;
         if (tmo_set) mem_timeout <= 1'b1;
      end
   end

   assign state = cur;
   assign busy  = (cur == S_T0) || (cur == S_T1) || (cur == S_T2) ||
                  (cur == S_T3) || (cur == S_T4) || (cur == S_T5);

endmodule

// File: tb/tb_mini_src_step_ctrl.sv
// Directed bench for mini_src_step_ctrl: fetch/execute sequences, memory wait and
// timeout, single-step, illegal/halt decode and asynchronous clear.
module tb_mini_src_step_ctrl;

   logic        clock = 1'b0;
   logic        clear = 1'b0;
   logic [31:0] ir = 32'd0;
   logic        mem_rdy = 1'b0, run = 1'b0, step_en = 1'b0, step_req = 1'b0;
   logic PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin;
   logic Gra, Grb, Grc, Rout, Rin, Yin, Cout, Zlowin, Zlowout;
   logic [4:0] alu_op;
   logic [3:0] state;
   logic busy, illegal, mem_timeout;
   int errors = 0;
   int checks = 0;

   mini_src_step_ctrl #(.MEM_TIMEOUT(15), .OP_MSB(31)) dut (
      .clock(clock), .clear(clear), .ir(ir), .mem_rdy(mem_rdy), .run(run),
      .step_en(step_en), .step_req(step_req),
      .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .PCin(PCin), .Read(Read),
      .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Gra(Gra), .Grb(Grb),
      .Grc(Grc), .Rout(Rout), .Rin(Rin), .Yin(Yin), .Cout(Cout),
      .Zlowin(Zlowin), .Zlowout(Zlowout), .alu_op(alu_op), .state(state),
      .busy(busy), .illegal(illegal), .mem_timeout(mem_timeout)
   );

   always #5 clock = ~clock;

   logic [16:0] sb;
   assign sb = {PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin,
                Gra, Grb, Grc, Rout, Rin, Yin, Cout, Zlowin, Zlowout};

   localparam logic [16:0] M_PCOUT = 17'h10000, M_MARIN = 17'h08000, M_INCPC = 17'h04000,
                           M_PCIN = 17'h02000, M_READ = 17'h01000, M_MDRIN = 17'h00800,
                           M_MDROUT = 17'h00400, M_IRIN = 17'h00200, M_GRA = 17'h00100,
                           M_GRB = 17'h00080, M_GRC = 17'h00040, M_ROUT = 17'h00020,
                           M_RIN = 17'h00010, M_YIN = 17'h00008, M_COUT = 17'h00004,
                           M_ZLIN = 17'h00002, M_ZLOUT = 17'h00001;
   localparam logic [16:0] E_T0 = M_PCOUT | M_MARIN | M_INCPC | M_PCIN;
   localparam logic [16:0] E_T1 = M_READ | M_MDRIN;
   localparam logic [16:0] E_T2 = M_MDROUT | M_IRIN;
   localparam logic [16:0] E_T3 = M_GRB | M_ROUT | M_YIN;
   localparam logic [16:0] E_T4I = M_COUT | M_ZLIN;
   localparam logic [16:0] E_T4R = M_GRC | M_ROUT | M_ZLIN;
   localparam logic [16:0] E_T5 = M_ZLOUT | M_GRA | M_RIN;

   localparam logic [3:0] ST_IDLE = 4'b0000, ST_T0 = 4'b0111, ST_T1 = 4'b1000,
                          ST_T2 = 4'b1001, ST_T3 = 4'b1010, ST_T4 = 4'b1011,
                          ST_T5 = 4'b1100, ST_ERR = 4'b1110, ST_HALT = 4'b1111;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Called at posedge+1; checks the current cycle, then advances one edge.
   task automatic cyc(input string tag, input logic [3:0] st, input logic [16:0] s,
                      input logic [4:0] alu, input logic bsy);
      #1;
      chk({tag, ".state"}, 32'(state), 32'(st));
      chk({tag, ".strobes"}, 32'(sb), 32'(s));
      chk({tag, ".alu_op"}, 32'(alu_op), 32'(alu));
      chk({tag, ".busy"}, 32'(busy), 32'(bsy));
      @(posedge clock); #1;
   endtask

   task automatic do_reset(input string tag);
      clear = 1'b0;
      #1;
      chk({tag, ".rst_state"}, 32'(state), 32'(ST_IDLE));
      chk({tag, ".rst_strobes"}, 32'(sb), 32'd0);
      chk({tag, ".rst_alu"}, 32'(alu_op), 32'd0);
      chk({tag, ".rst_flags"}, 32'({illegal, mem_timeout, busy}), 32'd0);
      @(posedge clock); #1;
      clear = 1'b1;
   endtask

   initial begin
      @(posedge clock); #1;
      do_reset("init");

      // addi back-to-back, then run dropped at T2 of the second instruction
      ir = {5'b01100, 27'h0}; run = 1'b1; mem_rdy = 1'b1;
      cyc("addi.idle", ST_IDLE, 17'd0, 5'd0, 1'b0);
      cyc("addi.t0", ST_T0, E_T0, 5'd0, 1'b1);
      cyc("addi.t1", ST_T1, E_T1, 5'd0, 1'b1);
      cyc("addi.t2", ST_T2, E_T2, 5'd0, 1'b1);
      cyc("addi.t3", ST_T3, E_T3, 5'd0, 1'b1);
      cyc("addi.t4", ST_T4, E_T4I, 5'b00011, 1'b1);
      cyc("addi.t5", ST_T5, E_T5, 5'd0, 1'b1);
      cyc("addi2.t0", ST_T0, E_T0, 5'd0, 1'b1);
      cyc("addi2.t1", ST_T1, E_T1, 5'd0, 1'b1);
      run = 1'b0;
      cyc("addi2.t2", ST_T2, E_T2, 5'd0, 1'b1);
      cyc("addi2.t3", ST_T3, E_T3, 5'd0, 1'b1);
      cyc("addi2.t4", ST_T4, E_T4I, 5'b00011, 1'b1);
      cyc("addi2.t5", ST_T5, E_T5, 5'd0, 1'b1);
      cyc("addi2.idle", ST_IDLE, 17'd0, 5'd0, 1'b0);

      // sub with memory ready on the 4th T1 cycle
      ir = {5'b00100, 27'h0}; run = 1'b1;
      cyc("sub.idle", ST_IDLE, 17'd0, 5'd0, 1'b0);
      mem_rdy = 1'b0;
      cyc("sub.t0", ST_T0, E_T0, 5'd0, 1'b1);
      for (int i = 0; i < 3; i++) cyc("sub.t1w", ST_T1, M_READ, 5'd0, 1'b1);
      mem_rdy = 1'b1;
      cyc("sub.t1r", ST_T1, E_T1, 5'd0, 1'b1);
      cyc("sub.t2", ST_T2, E_T2, 5'd0, 1'b1);
      cyc("sub.t3", ST_T3, E_T3, 5'd0, 1'b1);
      cyc("sub.t4", ST_T4, E_T4R, 5'b00100, 1'b1);
      run = 1'b0;
      cyc("sub.t5", ST_T5, E_T5, 5'd0, 1'b1);
      cyc("sub.idle2", ST_IDLE, 17'd0, 5'd0, 1'b0);

      // illegal opcode 11111
      ir = {5'b11111, 27'h0}; run = 1'b1;
      cyc("ill.idle", ST_IDLE, 17'd0, 5'd0, 1'b0);
      cyc("ill.t0", ST_T0, E_T0, 5'd0, 1'b1);
      cyc("ill.t1", ST_T1, E_T1, 5'd0, 1'b1);
      cyc("ill.t2", ST_T2, E_T2, 5'd0, 1'b1);
      cyc("ill.t3", ST_T3, 17'd0, 5'd0, 1'b1);
      chk("ill.flag", 32'(illegal), 32'd1);
      cyc("ill.err", ST_ERR, 17'd0, 5'd0, 1'b0);
      cyc("ill.err2", ST_ERR, 17'd0, 5'd0, 1'b0);
      do_reset("ill");

      // halt opcode 11011
      ir = {5'b11011, 27'h0};
      cyc("hlt.idle", ST_IDLE, 17'd0, 5'd0, 1'b0);
      cyc("hlt.t0", ST_T0, E_T0, 5'd0, 1'b1);
      cyc("hlt.t1", ST_T1, E_T1, 5'd0, 1'b1);
      cyc("hlt.t2", ST_T2, E_T2, 5'd0, 1'b1);
      cyc("hlt.t3", ST_T3, 17'd0, 5'd0, 1'b1);
      cyc("hlt.halt", ST_HALT, 17'd0, 5'd0, 1'b0);
      chk("hlt.illegal", 32'(illegal), 32'd0);
      cyc("hlt.halt2", ST_HALT, 17'd0, 5'd0, 1'b0);
      do_reset("hlt");

      // memory timeout: 16 T1 cycles then ERR
      ir = {5'b01100, 27'h0}; mem_rdy = 1'b0;
      cyc("tmo.idle", ST_IDLE, 17'd0, 5'd0, 1'b0);
      cyc("tmo.t0", ST_T0, E_T0, 5'd0, 1'b1);
      for (int i = 0; i < 16; i++) cyc("tmo.t1", ST_T1, M_READ, 5'd0, 1'b1);
      chk("tmo.flag", 32'(mem_timeout), 32'd1);
      cyc("tmo.err", ST_ERR, 17'd0, 5'd0, 1'b0);
      cyc("tmo.err2", ST_ERR, 17'd0, 5'd0, 1'b0);
      chk("tmo.illegal", 32'(illegal), 32'd0);
      do_reset("tmo");

      // clear mid-T4 kills Zlowin immediately
      mem_rdy = 1'b1;
      cyc("clr.idle", ST_IDLE, 17'd0, 5'd0, 1'b0);
      cyc("clr.t0", ST_T0, E_T0, 5'd0, 1'b1);
      cyc("clr.t1", ST_T1, E_T1, 5'd0, 1'b1);
      cyc("clr.t2", ST_T2, E_T2, 5'd0, 1'b1);
      cyc("clr.t3", ST_T3, E_T3, 5'd0, 1'b1);
      #1;
      chk("clr.t4_zlowin", 32'(Zlowin), 32'd1);
      do_reset("clr");

      // single-step: pulse step_req every 4th cycle, mem_rdy high throughout
      step_en = 1'b1; step_req = 1'b0;
      begin
         logic [3:0]  sts [7] = '{ST_IDLE, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5};
         logic [16:0] hold[7] = '{17'd0, 17'd0, M_READ, 17'd0, 17'd0, 17'd0, 17'd0};
         logic [16:0] fire[7] = '{17'd0, E_T0, E_T1, E_T2, E_T3, E_T4I, E_T5};
         logic [4:0]  alus[7] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'b00011, 5'd0};
         for (int p = 0; p < 7; p++) begin
            for (int k = 0; k < 3; k++) begin
               step_req = 1'b0;
               cyc("stp.hold", sts[p], hold[p], 5'd0, p != 0);
            end
            step_req = 1'b1;
            cyc("stp.fire", sts[p], fire[p], alus[p], p != 0);
         end
         step_req = 1'b0;
         cyc("stp.done", ST_T0, 17'd0, 5'd0, 1'b1);
      end
      step_en = 1'b0; run = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mini_src_step_ctrl.md
# mini_src_step_ctrl

Parametrised T-state control sequencer for the Mini-SRC datapath. It fetches and executes R-type and I-type ALU instructions by driving the datapath strobes, one T-state at a time. It generalises the fixed T0–T5 add-immediate sequence with opcode decode, a memory-ready handshake with timeout, a single-step mode and halt/fault states. It sits beside `Datapath` and drives its control ports directly.

## Interface
- MEM_TIMEOUT, 15: max T1 cycles with mem_rdy low before fault (1..255)
- OP_MSB, 31: IR bit index of opcode MSB; opcode = ir[OP_MSB -: 5]
- clock  in  1  rising-edge clock
- clear  in  1  reset, asynchronous, active-low
- ir  in  32  instruction register contents, valid from T3 onward
- mem_rdy  in  1  memory has read data on MDR input this cycle
- run  in  1  level; 1 = fetch next instruction at T5/IDLE boundary
- step_en  in  1  single-step mode enable
- step_req  in  1  single-step advance request, sampled each cycle
- PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin  out  1 each  fetch strobes
- Gra, Grb, Grc, Rout, Rin, Yin, Cout, Zlowin, Zlowout  out  1 each  execute strobes
- alu_op  out  5  ALU operation code, valid when Zlowin=1, else 0
- state  out  4  current state code
- busy  out  1  state is in T0..T5
- illegal  out  1  sticky: undecodable opcode seen
- mem_timeout  out  1  sticky: T1 exceeded MEM_TIMEOUT

## Operation
- State codes:
  - IDLE=0000
  - T0=0111, T1=1000, T2=1001, T3=1010, T4=1011, T5=1100
  - ERR=1110, HALT=1111
- Opcodes:
  - R-type: add 00011, sub 00100, and 00101, or 00110
  - I-type: addi 01100, andi 01101, ori 01110
  - Control: nop 11010, halt 11011
  - Anything else is illegal.
- adv = !step_en | step_req. The state changes only on edges where adv=1.
- Strobe gating: all strobes except Read are ANDed with adv, so in step mode each strobe fires exactly once per T-state.
- IDLE:
  - No strobes.
  - Goes to T0 when run=1 and adv=1.
- T0:
  - Strobes: PCout, MARin, IncPC, PCin.
  - Goes to T1.
- T1:
  - Read is held high for the whole state.
  - MDRin = mem_rdy & adv.
  - Goes to T2 when mem_rdy & adv.
  - An 8-bit wait counter increments on each T1 cycle with mem_rdy=0, and clears on entry to T1.
  - When the count reaches MEM_TIMEOUT with mem_rdy still low: go to ERR and set mem_timeout.
- T2:
  - Strobes: MDRout, IRin.
  - Goes to T3.
- T3, decoded from ir:
  - R/I-type: Grb, Rout, Yin; goes to T4.
  - nop: no strobes; goes to T0 if run, else IDLE.
  - halt: goes to HALT.
  - illegal: no strobes; goes to ERR and sets illegal.
- T4:
  - R-type: Grc, Rout, Zlowin; alu_op = opcode.
  - I-type: Cout, Zlowin; alu_op = add 00011 / and 00101 / or 00110 for addi / andi / ori.
- T5:
  - Strobes: Zlowout, Gra, Rin.
  - Goes to T0 if run=1, else IDLE.
- ERR and HALT:
  - All strobes 0; busy=0.
  - Exit only via clear.
- Dropping run mid-instruction does not abort; the instruction completes through T5.
- Strobes are combinational from the state register, step_req and mem_rdy.

## Timing
- Reset (clear=0):
  - state=IDLE, counter=0, illegal=0, mem_timeout=0.
  - All strobes and alu_op = 0, asynchronously, in the same cycle clear falls.
- Latency:
  - run rising in IDLE: T0 is on the next edge.
  - Zero-wait instruction: 6 cycles, T0..T5.
  - Back-to-back instructions with run=1: T5 → T0 with no idle cycle.
- Each T1 wait cycle adds 1 cycle. Worst case before fault: MEM_TIMEOUT+1 cycles in T1.
- mem_rdy and step_req both high in T1 in step mode: advance, MDRin pulses once.
- mem_rdy high with step_en=1, step_req=0: hold in T1, MDRin=0, counter does not increment.
- Step mode with timeout: the counter counts only mem_rdy=0 cycles, so a timeout can fire without step_req.
- step_en toggled mid-instruction: takes effect on the same cycle (adv recomputed).

## Test plan
- addi r? (ir[31:27]=01100), mem_rdy=1, run=1:
  - state sequence 0111,1000,1001,1010,1011,1100 in 6 cycles.
  - T4: Cout=Zlowin=1, alu_op=00011.
  - T5: Zlowout=Gra=Rin=1.
  - Next cycle: T0.
- sub (00100) with mem_rdy rising 3 cycles after T1 entry:
  - T1 lasts 4 cycles with Read=1 throughout.
  - MDRin=1 only in the 4th cycle.
  - T4: Grc=Rout=Zlowin=1, alu_op=00100.
- mem_rdy held 0, MEM_TIMEOUT=15:
  - After 16 T1 cycles: state=1110, mem_timeout=1, busy=0.
  - Stays in ERR until clear.
- step_en=1, step_req pulsed every 4th cycle:
  - Each T-state's strobes are high for exactly one cycle.
  - state is stable between pulses.
  - A full addi completes after 7 pulses (IDLE→T0 plus 6 pulses).
- Opcodes 11111 and 11011 at T3:
  - 11111: ERR with illegal=1 and no Yin pulse.
  - 11011: HALT, illegal=0.
- Mid-instruction events:
  - clear driven low mid-T4: Zlowin drops immediately and state=0000.
  - run dropped during T2: instruction finishes T5, then state=0000.
